// File: rtl/alu_issue_pkg.sv
// Shared definitions for the decode-to-ALU issue stage: datapath width,
// ALU opcodes and the writeback forwarding helper.
package alu_issue_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    OP_JALR = 5'b00000,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SLTI = 5'b01000,
    OP_JAL  = 5'b10000
  } alu_op_e;

  localparam logic [4:0] OP_RESET = OP_ADD;

  // x0 is hardwired to zero, so a writeback to it must never be forwarded
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic            we,
    input logic [4:0]      wrd,
    input logic [4:0]      rs,
    input logic [XLEN-1:0] wdata,
    input logic [XLEN-1:0] rdata
  );
    if (we && (wrd != 5'd0) && (wrd == rs)) begin
      return wdata;
    end else begin
      return rdata;
    end
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Decode-side request and ALU-side response of the issue stage in one bundle.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic            in_alusrc;
  logic [4:0]      in_aluop;
  logic [4:0]      in_rd;
  logic            in_regwrite;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      alu_op;
  logic [4:0]      out_rd;
  logic            out_regwrite;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
           in_imm, in_alusrc, in_aluop, in_rd, in_regwrite, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, out_rd, out_regwrite
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
           in_imm, in_alusrc, in_aluop, in_rd, in_regwrite, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, out_rd, out_regwrite
  );

endinterface

// File: rtl/alu_operand_mux.sv
// Combinational ALU operand selection with optional writeback forwarding,
// enabled by defining ALU_ISSUE_FORWARD_EN.
module alu_operand_mux
  import alu_issue_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            alusrc,
  input  logic [4:0]      aluop,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b
);

  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;

`ifdef ALU_ISSUE_FORWARD_EN
  assign rs1_val_s = fwd_sel(wb_we, wb_rd, rs1, wb_data, rs1_data);
  assign rs2_val_s = fwd_sel(wb_we, wb_rd, rs2, wb_data, rs2_data);
`else
  // Register indices and the writeback bus only matter when forwarding
  logic unused_fwd_s;
  assign unused_fwd_s = ^{wb_we, wb_rd, wb_data, rs1, rs2};
  assign rs1_val_s    = rs1_data;
  assign rs2_val_s    = rs2_data;
`endif

  // Jumps take the immediate as B; jal also swaps A for the PC
  always_comb begin
    a = rs1_val_s;
    b = rs2_val_s;
    case (aluop)
      OP_JAL: begin
        a = pc;
        b = imm;
      end
      OP_JALR: begin
        a = rs1_val_s;
        b = imm;
      end
      default: begin
        a = rs1_val_s;
        if (alusrc) begin
          b = imm;
        end else begin
          b = rs2_val_s;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Single-entry decode-to-ALU pipeline register with flush and backpressure.
// Writeback forwarding into the operands is enabled by ALU_ISSUE_FORWARD_EN.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  alu_issue_if.slave      bus
);

  logic            ready_s;
  logic [XLEN-1:0] a_s;
  logic [XLEN-1:0] b_s;

  logic            valid_r;
  logic            regwrite_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;
  logic [4:0]      op_r;
  logic [4:0]      rd_r;

  assign ready_s = (!valid_r || bus.out_ready) && !flush && !rst;

  alu_operand_mux u_mux (
    .pc       (bus.in_pc),
    .rs1      (bus.in_rs1),
    .rs2      (bus.in_rs2),
    .rs1_data (bus.in_rs1_data),
    .rs2_data (bus.in_rs2_data),
    .imm      (bus.in_imm),
    .alusrc   (bus.in_alusrc),
    .aluop    (bus.in_aluop),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .a        (a_s),
    .b        (b_s)
  );

  // Flush only drops the valid/write qualifiers; stale data is harmless
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      regwrite_r <= 1'b0;
      a_r        <= {XLEN{1'b0}};
      b_r        <= {XLEN{1'b0}};
      op_r       <= OP_RESET;
      rd_r       <= 5'd0;
    end else if (flush) begin
      valid_r    <= 1'b0;
      regwrite_r <= 1'b0;
    end else if (bus.in_valid && ready_s) begin
      valid_r    <= 1'b1;
      regwrite_r <= bus.in_regwrite;
      a_r        <= a_s;
      b_r        <= b_s;
      op_r       <= bus.in_aluop;
      rd_r       <= bus.in_rd;
    end else if (bus.out_ready) begin
      valid_r    <= 1'b0;
      regwrite_r <= 1'b0;
    end
  end

  assign bus.in_ready     = ready_s;
  assign bus.out_valid    = valid_r;
  assign bus.out_regwrite = regwrite_r;
  assign bus.alu_a        = a_r;
  assign bus.alu_b        = b_r;
  assign bus.alu_op       = op_r;
  assign bus.out_rd       = rd_r;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios followed by random traffic, all
// checked against an instruction-level reference model.
module tb_alu_issue;
  import alu_issue_pkg::*;

`ifdef ALU_ISSUE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  alu_issue_if bus ();

  alu_issue dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model of the held instruction
  bit          m_valid = 1'b0;
  bit          m_rw    = 1'b0;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_op, m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rsval(input logic [4:0] idx, input logic [31:0] d);
    if (FWD && wb_we && wb_rd != 5'd0 && wb_rd == idx) return wb_data;
    return d;
  endfunction

  function automatic bit exp_ready();
    return (!m_valid || bus.out_ready) && !flush && !rst;
  endfunction

  task automatic model_step();
    bit rdy;
    rdy = exp_ready();
    if (rst) begin
      m_valid = 1'b0; m_rw = 1'b0; m_a = 32'd0; m_b = 32'd0;
      m_op = 5'b00011; m_rd = 5'd0;
    end else if (flush) begin
      m_valid = 1'b0; m_rw = 1'b0;
    end else if (bus.in_valid && rdy) begin
      m_valid = 1'b1;
      m_rw    = bus.in_regwrite;
      m_op    = bus.in_aluop;
      m_rd    = bus.in_rd;
      m_a     = (bus.in_aluop == 5'b10000) ? bus.in_pc : rsval(bus.in_rs1, bus.in_rs1_data);
      if (bus.in_aluop == 5'b10000 || bus.in_aluop == 5'b00000 || bus.in_alusrc)
        m_b = bus.in_imm;
      else
        m_b = rsval(bus.in_rs2, bus.in_rs2_data);
    end else if (bus.out_ready) begin
      m_valid = 1'b0; m_rw = 1'b0;
    end
  endtask

  task automatic cycle();
    #1;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready()});
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk("out_regwrite", {31'd0, bus.out_regwrite}, {31'd0, m_rw});
    if (m_valid) begin
      chk("alu_a", bus.alu_a, m_a);
      chk("alu_b", bus.alu_b, m_b);
      chk("alu_op", {27'd0, bus.alu_op}, {27'd0, m_op});
      chk("out_rd", {27'd0, bus.out_rd}, {27'd0, m_rd});
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic alusrc, input logic [4:0] op, input logic [4:0] rd,
                       input logic rw);
    bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_rs1_data = d1; bus.in_rs2_data = d2; bus.in_imm = imm;
    bus.in_alusrc = alusrc; bus.in_aluop = op; bus.in_rd = rd; bus.in_regwrite = rw;
  endtask

  initial begin
    flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    bus.out_ready = 1'b1;
    drive(32'h44, 5'd1, 5'd2, 32'h9, 32'h8, 32'h7, 1'b0, 5'b00100, 5'd3, 1'b1);

    // reset held two cycles while decode keeps presenting an instruction
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_op", {27'd0, bus.alu_op}, 32'd3);
    chk("rst_a", bus.alu_a, 32'd0);
    chk("rst_b", bus.alu_b, 32'd0);
    chk("rst_rd", {27'd0, bus.out_rd}, 32'd0);

    drive(32'h0, 5'd1, 5'd2, 32'd5, 32'hFFFF_FFFD, 32'h99, 1'b0, 5'b00011, 5'd4, 1'b1);
    cycle();
    chk("add_a", bus.alu_a, 32'd5);
    chk("add_b", bus.alu_b, 32'hFFFF_FFFD);
    chk("add_op", {27'd0, bus.alu_op}, 32'd3);
    chk("add_valid", {31'd0, bus.out_valid}, 32'd1);

    drive(32'h100, 5'd1, 5'd2, 32'h3, 32'h4, 32'h20, 1'b0, 5'b10000, 5'd1, 1'b1);
    cycle();
    chk("jal_a", bus.alu_a, 32'h100);
    chk("jal_b", bus.alu_b, 32'h20);

    drive(32'h200, 5'd1, 5'd2, 32'h40, 32'h4, 32'h8, 1'b0, 5'b00000, 5'd1, 1'b1);
    cycle();
    chk("jalr_a", bus.alu_a, 32'h40);
    chk("jalr_b", bus.alu_b, 32'h8);

    // backpressure: held instruction must stay put while a new one waits
    bus.out_ready = 1'b0;
    drive(32'h0, 5'd3, 5'd4, 32'h77, 32'h66, 32'h1, 1'b0, 5'b01000, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_a", bus.alu_a, 32'h40);
      chk("stall_op", {27'd0, bus.alu_op}, 32'd0);
      chk("stall_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("release_a", bus.alu_a, 32'h77);
    chk("release_op", {27'd0, bus.alu_op}, 32'h8);

    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
    drive(32'h0, 5'd7, 5'd2, 32'h11, 32'h2, 32'h0, 1'b0, 5'b00011, 5'd5, 1'b1);
    cycle();
    chk("fwd_a", bus.alu_a, FWD ? 32'h55 : 32'h11);
    wb_rd = 5'd0;
    cycle();
    chk("fwd_x0_a", bus.alu_a, 32'h11);
    wb_we = 1'b0;

    // flush while stalled with a new instruction offered
    bus.out_ready = 1'b0;
    flush = 1'b1;
    cycle();
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_rw", {31'd0, bus.out_regwrite}, 32'd0);
    flush = 1'b0;

    for (int i = 0; i < 400; i++) begin
      drive($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
            $urandom, 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      case ($urandom_range(0, 5))
        0: bus.in_aluop = 5'b10000;
        1: bus.in_aluop = 5'b00000;
        default: ;
      endcase
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 9) == 0);
      rst           = ($urandom_range(0, 49) == 0);
      wb_we         = 1'($urandom);
      wb_rd         = 5'($urandom_range(0, 3));
      wb_data       = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue
Interface
REQ-001 XLEN, 32, operand and PC width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 flush  in  1  discard held and incoming instruction (branch/jump redirect).
REQ-005 in_valid  in  1  decode stage presents an instruction.
REQ-006 in_ready  out  1  stage accepts the instruction this cycle.
REQ-007 in_pc  in  XLEN  PC of the incoming instruction.
REQ-008 in_rs1  in  5  rs1 register index.
REQ-009 in_rs2  in  5  rs2 register index.
REQ-010 in_rs1_data  in  XLEN  register-file read data for rs1.
REQ-011 in_rs2_data  in  XLEN  register-file read data for rs2.
REQ-012 in_imm  in  XLEN  sign-extended immediate.
REQ-013 in_alusrc  in  1  1 = B operand is in_imm, 0 = rs2 data.
REQ-014 in_aluop  in  5  ALU opcode: add 00011, sub 00100, slti 01000, jal 10000, jalr 00000.
REQ-015 in_rd  in  5  destination register index.
REQ-016 in_regwrite  in  1  instruction writes rd.
REQ-017 wb_we  in  1  writeback stage writes the register file this cycle.
REQ-018 wb_rd  in  5  writeback destination index.
REQ-019 wb_data  in  XLEN  writeback data.
REQ-020 out_valid  out  1  registered instruction valid toward ALU.
REQ-021 out_ready  in  1  ALU/execute consumes the instruction this cycle.
REQ-022 alu_a  out  XLEN  registered ALU operand A (signed).
REQ-023 alu_b  out  XLEN  registered ALU operand B (signed).
REQ-024 alu_op  out  5  registered ALU opcode.
REQ-025 out_rd  out  5  registered destination index.
REQ-026 out_regwrite  out  1  registered write enable; forced 0 when out_valid=0.
Function
REQ-027 Single-entry pipeline register between decode and ALU; in_ready SHALL equal (!out_valid || out_ready) && !flush, combinational.
REQ-028 Transfer when in_valid && in_ready: next cycle out_valid=1 and all out_* / alu_* hold captured values; latency exactly 1 cycle.
REQ-029 out_valid && !out_ready: all outputs SHALL hold unchanged (stall); no capture.
REQ-030 out_valid && out_ready && !in_valid: out_valid SHALL fall to 0 next cycle.
REQ-031 Operand select at capture: alu_op=jal -> A=in_pc, B=in_imm; jalr -> A=rs1 value, B=in_imm; otherwise A=rs1 value, B = in_alusrc ? in_imm : rs2 value.
REQ-032 Unlisted opcodes SHALL pass through unchanged with the default operand rule.
REQ-033 flush SHALL clear out_valid and out_regwrite next cycle, override any capture and stall that cycle; data registers may keep stale values.
REQ-034 No arithmetic is performed; operands are XLEN-bit, no truncation or extension beyond in_imm as given.
Reset
REQ-035 rst=1 at a clock edge SHALL set out_valid=0, out_regwrite=0, out_rd=0, alu_a=0, alu_b=0, alu_op=00011, overriding flush and any transfer; in_ready=0 while rst=1.
Configuration
REQ-036 Macro ALU_ISSUE_FORWARD_EN defined: rs1/rs2 value = wb_data when wb_we && wb_rd!=0 && wb_rd==in_rsX, else in_rsX_data; undefined: rs value = in_rsX_data and wb_* ports are present but ignored.
Structure
REQ-037 Shared package holds XLEN, the five ALU opcode constants, and the reset opcode; sub-module alu_operand_mux (forwarding + A/B selection, combinational) is instantiated once.
Verification
REQ-038 rst held 2 cycles with in_valid=1 -> out_valid=0, alu_op=00011, alu_a=alu_b=0 after release until first transfer.
REQ-039 add, rs1_data=5, rs2_data=-3, alusrc=0 -> next cycle alu_a=5, alu_b=-3, alu_op=00011, out_valid=1.
REQ-040 jal, in_pc=0x100, in_imm=0x20 -> alu_a=0x100, alu_b=0x20; jalr, rs1_data=0x40, imm=8 -> alu_a=0x40, alu_b=8.
REQ-041 out_ready=0 for 3 cycles with new in_valid=1 -> outputs frozen, in_ready=0; out_ready=1 -> new instruction appears next cycle.
REQ-042 FORWARD_EN: wb_we=1, wb_rd=in_rs1=7, wb_data=0x55, rs1_data=0x11 -> alu_a=0x55; repeat with wb_rd=0 -> alu_a=0x11; without macro -> 0x11.
REQ-043 flush asserted together with in_valid and out_ready=0 -> next cycle out_valid=0, out_regwrite=0.
